// File: rtl/qerv_immdec_w.sv
// qerv_immdec_w -- W-bit-per-beat serial immediate decoder.
//
// Captures instruction bits [31:7] from the instruction bus, latches the
// register addresses, builds the 32-bit immediate for the selected format
// and shifts it out LSB-first, W bits per beat, with sign extension.
// A beat counter marks the last beat. A sticky flag records sequencing
// errors between the core's strobes and the decoder state.
//
// Optional build macro: QERV_IMMDEC_CSR_EN
//   defined   -> serial zero-extended rs1-field shifter drives o_csr_imm
//   undefined -> no CSR shifter, o_csr_imm tied to 0
//
// Parameters:
//   W            bits per beat (1, 2, 4 or 8); N = 32/W beats per immediate
// Ports:
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_wb_en      instruction bus ack, captures i_wb_rdt
//   i_wb_rdt     instruction bits [31:7]
//   i_imm_type   0=I 1=S 2=B 3=U 4=J (5..7 decode as I), sampled in CAPT
//   i_cnt_en     beat strobe
//   i_cnt_done   core's last-beat indication (consistency check only)
//   i_csr_imm_en gate for o_csr_imm
//   o_rd_addr    instr[11:7]
//   o_rs1_addr   instr[19:15]
//   o_rs2_addr   instr[24:20]
//   o_imm        current immediate slice
//   o_csr_imm    current CSR immediate slice
//   o_last       last beat of the immediate
//   o_err        sticky sequence error
module qerv_immdec_w #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wb_en,
  input  logic [24:0]  i_wb_rdt,
  input  logic [2:0]   i_imm_type,
  input  logic         i_cnt_en,
  input  logic         i_cnt_done,
  input  logic         i_csr_imm_en,
  output logic [4:0]   o_rd_addr,
  output logic [4:0]   o_rs1_addr,
  output logic [4:0]   o_rs2_addr,
  output logic [W-1:0] o_imm,
  output logic [W-1:0] o_csr_imm,
  output logic         o_last,
  output logic         o_err
);

  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("qerv_immdec_w: W must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CAPT, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [31:7]    raw_q;
  logic [31:0]    shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     rd_q, rs1_q, rs2_q;
  logic           err_q;
  logic [31:0]    imm_asm;
  logic           last;
  logic           seq_err;

  assign last = (state_q == SHIFT) && (cnt_q == CW'(N - 1));

  // Immediate assembly from the captured raw bits.
  always_comb begin
    imm_asm = {{20{raw_q[31]}}, raw_q[31:20]};
    case (i_imm_type)
      3'd1: imm_asm = {{20{raw_q[31]}}, raw_q[31:25], raw_q[11:7]};
      3'd2: imm_asm = {{20{raw_q[31]}}, raw_q[7], raw_q[30:25], raw_q[11:8], 1'b0};
      3'd3: imm_asm = {raw_q[31:12], 12'b0};
      3'd4: imm_asm = {{12{raw_q[31]}}, raw_q[19:12], raw_q[20], raw_q[30:21], 1'b0};
      default: imm_asm = {{20{raw_q[31]}}, raw_q[31:20]};
    endcase
  end

  // A beat strobe outside SHIFT, a done flag off the last beat, or a last
  // beat without done all mean the core and decoder disagree.
  assign seq_err = (i_cnt_en && (state_q != SHIFT))
                 | (i_cnt_done && !last)
                 | (i_cnt_en && last && !i_cnt_done);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (i_wb_en) begin
      // Capture wins over any beat: a restart discards the old immediate.
      state_d = CAPT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CAPT: begin
          state_d = SHIFT;
          shreg_d = imm_asm;
        end
        SHIFT: begin
          if (i_cnt_en) begin
            shreg_d = {{W{shreg_q[31]}}, shreg_q[31:W]};
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      raw_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | seq_err;
      if (i_wb_en) begin
        raw_q <= i_wb_rdt;
        rd_q  <= i_wb_rdt[4:0];
        rs1_q <= i_wb_rdt[12:8];
        rs2_q <= i_wb_rdt[17:13];
      end
    end
  end

`ifdef QERV_IMMDEC_CSR_EN
  logic [31:0] csr_q, csr_d;

  always_comb begin
    csr_d = csr_q;
    if (!i_wb_en) begin
      if (state_q == CAPT) begin
        csr_d = {27'b0, raw_q[19:15]};
      end else if (state_q == SHIFT && i_cnt_en) begin
        csr_d = {{W{1'b0}}, csr_q[31:W]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csr_q <= '0;
    end else begin
      csr_q <= csr_d;
    end
  end

  assign o_csr_imm = (state_q == SHIFT && i_csr_imm_en) ? csr_q[W-1:0] : '0;
`else
  logic unused_csr_en;
  assign unused_csr_en = i_csr_imm_en;
  assign o_csr_imm     = '0;
`endif

  assign o_imm      = (state_q == SHIFT) ? shreg_q[W-1:0] : '0;
  assign o_last     = last;
  assign o_err      = err_q;
  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;

endmodule

// File: tb/tb_qerv_immdec_w.sv
// Directed bench for qerv_immdec_w: three instances (W=4, W=1, W=8) share
// the capture inputs and have private beat strobes. Expected immediates
// are hand-decoded 32-bit values sliced per beat.
module tb_qerv_immdec_w;

`ifdef QERV_IMMDEC_CSR_EN
  localparam bit CSR_BUILT = 1'b1;
`else
  localparam bit CSR_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [24:0] rdt = '0;
  logic [2:0]  imm_type = '0;
  logic        csr_en = 1'b0;
  logic        cnt_en4 = 1'b0, cnt_done4 = 1'b0;
  logic        cnt_en1 = 1'b0, cnt_done1 = 1'b0;
  logic        cnt_en8 = 1'b0, cnt_done8 = 1'b0;

  logic [4:0]  rd4, rs1_4, rs2_4;
  logic [3:0]  imm4, csr4;
  logic        last4, err4;
  logic [4:0]  rd1, unused_rs1_1, unused_rs2_1;
  logic [0:0]  imm1, unused_csr1;
  logic        last1, err1;
  logic [4:0]  rd8, unused_rs1_8, unused_rs2_8;
  logic [7:0]  imm8, unused_csr8;
  logic        last8, err8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qerv_immdec_w #(.W(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_imm_type(imm_type),
    .i_cnt_en(cnt_en4), .i_cnt_done(cnt_done4), .i_csr_imm_en(csr_en),
    .o_rd_addr(rd4), .o_rs1_addr(rs1_4), .o_rs2_addr(rs2_4),
    .o_imm(imm4), .o_csr_imm(csr4), .o_last(last4), .o_err(err4)
  );

  qerv_immdec_w #(.W(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_imm_type(imm_type),
    .i_cnt_en(cnt_en1), .i_cnt_done(cnt_done1), .i_csr_imm_en(csr_en),
    .o_rd_addr(rd1), .o_rs1_addr(unused_rs1_1), .o_rs2_addr(unused_rs2_1),
    .o_imm(imm1), .o_csr_imm(unused_csr1), .o_last(last1), .o_err(err1)
  );

  qerv_immdec_w #(.W(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_imm_type(imm_type),
    .i_cnt_en(cnt_en8), .i_cnt_done(cnt_done8), .i_csr_imm_en(csr_en),
    .o_rd_addr(rd8), .o_rs1_addr(unused_rs1_8), .o_rs2_addr(unused_rs2_8),
    .o_imm(imm8), .o_csr_imm(unused_csr8), .o_last(last8), .o_err(err8)
  );

  function automatic logic [7:0] imm_of(input int w);
    case (w)
      1:       return {7'b0, imm1};
      8:       return imm8;
      default: return {4'b0, imm4};
    endcase
  endfunction

  function automatic logic last_of(input int w);
    case (w)
      1:       return last1;
      8:       return last8;
      default: return last4;
    endcase
  endfunction

  function automatic logic err_of(input int w);
    case (w)
      1:       return err1;
      8:       return err8;
      default: return err4;
    endcase
  endfunction

  task automatic set_cnt(input int w, input logic en, input logic done);
    case (w)
      1: begin cnt_en1 = en; cnt_done1 = done; end
      8: begin cnt_en8 = en; cnt_done8 = done; end
      default: begin cnt_en4 = en; cnt_done4 = done; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle bus ack; returns two cycles later with the decoder in SHIFT.
  task automatic capture(input logic [31:0] instr, input logic [2:0] t);
    @(negedge clk);
    wb_en = 1'b1;
    rdt = instr[31:7];
    imm_type = t;
    @(negedge clk);
    wb_en = 1'b0;
    @(negedge clk);
  endtask

  // Drives N beats on one instance, checking each slice and o_last; an
  // optional 3-cycle stall before beat stall_at must not disturb anything.
  task automatic run_seq(input int w, input logic [31:0] exp_imm, input logic [31:0] exp_csr,
                         input int stall_at, input string name);
    int n;
    logic [31:0] mask;
    logic [7:0] exp_s, exp_c;
    n = 32 / w;
    mask = (32'h1 << w) - 32'h1;
    for (int b = 0; b < n; b++) begin
      exp_s = 8'((exp_imm >> (b * w)) & mask);
      exp_c = (csr_en && CSR_BUILT) ? 8'((exp_csr >> (b * w)) & mask) : 8'h0;
      for (int s = 0; s < ((b == stall_at) ? 4 : 1); s++) begin
        if (s > 0) begin
          set_cnt(w, 1'b0, 1'b0);
          @(negedge clk);
        end
        tests++;
        if (imm_of(w) !== exp_s) begin
          fails++;
          $display("FAIL %s imm W=%0d beat %0d: got %h want %h", name, w, b, imm_of(w), exp_s);
        end
        tests++;
        if (last_of(w) !== (b == n - 1)) begin
          fails++;
          $display("FAIL %s last W=%0d beat %0d: got %b want %b", name, w, b, last_of(w), (b == n - 1));
        end
        if (w == 4) begin
          tests++;
          if ({4'b0, csr4} !== exp_c) begin
            fails++;
            $display("FAIL %s csr_imm beat %0d: got %h want %h", name, b, csr4, exp_c);
          end
        end
      end
      set_cnt(w, 1'b1, (b == n - 1));
      @(negedge clk);
    end
    set_cnt(w, 1'b0, 1'b0);
    tests++;
    if (imm_of(w) !== 8'h0 || last_of(w) !== 1'b0 || err_of(w) !== 1'b0) begin
      fails++;
      $display("FAIL %s end W=%0d: imm=%h last=%b err=%b want 0/0/0", name, w, imm_of(w), last_of(w), err_of(w));
    end
    $display("[TB] %s W=%0d sequence of %0d beats done", name, w, n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (imm4 !== 4'h0 || csr4 !== 4'h0 || last4 !== 1'b0 || err4 !== 1'b0 ||
        rd4 !== 5'd0 || rs1_4 !== 5'd0 || rs2_4 !== 5'd0 || imm1 !== 1'b0 || imm8 !== 8'h0) begin
      fails++;
      $display("FAIL reset: imm4=%h csr4=%h last4=%b err4=%b rd=%0d rs1=%0d rs2=%0d imm1=%b imm8=%h want all 0",
               imm4, csr4, last4, err4, rd4, rs1_4, rs2_4, imm1, imm8);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    capture(32'hFFF10093, 3'd0);
    tests++;
    if (rd4 !== 5'd1 || rs1_4 !== 5'd2) begin
      fails++;
      $display("FAIL addi addr: rd=%0d rs1=%0d want 1/2", rd4, rs1_4);
    end
    run_seq(4, 32'hFFFFFFFF, 32'h0, -1, "addi");
  endtask

  task automatic test_sw();
    capture(32'h00512423, 3'd1);
    tests++;
    if (rs2_4 !== 5'd5) begin
      fails++;
      $display("FAIL sw rs2: got %0d want 5", rs2_4);
    end
    run_seq(4, 32'h00000008, 32'h0, -1, "sw");
  endtask

  task automatic test_lui_beq();
    capture(32'h123450B7, 3'd3);
    run_seq(4, 32'h12345000, 32'h0, -1, "lui");
    capture(32'h00000863, 3'd2);
    run_seq(4, 32'h00000010, 32'h0, -1, "beq");
  endtask

  task automatic test_jal_widths();
    capture(32'hFFDFF06F, 3'd4);
    tests++;
    if (rd8 !== 5'd0 || rd1 !== 5'd0) begin
      fails++;
      $display("FAIL jal rd: W8=%0d W1=%0d want 0", rd8, rd1);
    end
    run_seq(8, 32'hFFFFFFFC, 32'h0, -1, "jal");
    run_seq(1, 32'hFFFFFFFC, 32'h0, -1, "jal");
    capture(32'hFFDFF06F, 3'd4);
    run_seq(8, 32'hFFFFFFFC, 32'h0, 2, "jal_stall");
    run_seq(1, 32'hFFFFFFFC, 32'h0, 13, "jal_stall");
  endtask

  task automatic test_csr_imm();
    csr_en = 1'b1;
    capture(32'h300AD073, 3'd0);
    tests++;
    if (rs1_4 !== 5'd21) begin
      fails++;
      $display("FAIL csrrwi rs1: got %0d want 21", rs1_4);
    end
    run_seq(4, 32'h00000300, 32'h00000015, 3, "csrrwi");
    csr_en = 1'b0;
  endtask

  task automatic test_idle_err();
    do_reset();
    tests++;
    if (err4 !== 1'b0) begin
      fails++;
      $display("FAIL idle_err pre: got %b want 0", err4);
    end
    set_cnt(4, 1'b1, 1'b0);
    @(negedge clk);
    set_cnt(4, 1'b0, 1'b0);
    tests++;
    if (err4 !== 1'b1) begin
      fails++;
      $display("FAIL idle_err set: got %b want 1", err4);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (err4 !== 1'b1 || err1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_err sticky: err4=%b err1=%b want 1/0", err4, err1);
    end
    $display("[TB] idle beat strobe error checked");
  endtask

  task automatic test_done_early();
    do_reset();
    capture(32'hFFF10093, 3'd0);
    for (int b = 0; b < 3; b++) begin
      set_cnt(4, 1'b1, 1'b0);
      @(negedge clk);
    end
    tests++;
    if (err4 !== 1'b0) begin
      fails++;
      $display("FAIL done_early pre: got %b want 0", err4);
    end
    set_cnt(4, 1'b1, 1'b1);
    @(negedge clk);
    set_cnt(4, 1'b0, 1'b0);
    tests++;
    if (err4 !== 1'b1) begin
      fails++;
      $display("FAIL done_early: got %b want 1", err4);
    end
    $display("[TB] early cnt_done error checked");
  endtask

  task automatic test_restart();
    do_reset();
    capture(32'hFFF10093, 3'd0);
    for (int b = 0; b < 4; b++) begin
      set_cnt(4, 1'b1, 1'b0);
      @(negedge clk);
    end
    set_cnt(4, 1'b0, 1'b0);
    capture(32'h123450B7, 3'd3);
    run_seq(4, 32'h12345000, 32'h0, -1, "restart");
  endtask

  task automatic test_reset_mid();
    do_reset();
    capture(32'hFFF10093, 3'd0);
    for (int b = 0; b < 3; b++) begin
      set_cnt(4, 1'b1, 1'b0);
      @(negedge clk);
    end
    set_cnt(4, 1'b0, 1'b0);
    tests++;
    if (rd4 !== 5'd1 || imm4 !== 4'hF) begin
      fails++;
      $display("FAIL reset_mid pre: rd=%0d imm=%h want 1/F", rd4, imm4);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (imm4 !== 4'h0 || csr4 !== 4'h0 || last4 !== 1'b0 || err4 !== 1'b0 ||
        rd4 !== 5'd0 || rs1_4 !== 5'd0 || rs2_4 !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid async: imm=%h csr=%h last=%b err=%b rd=%0d rs1=%0d rs2=%0d want all 0",
               imm4, csr4, last4, err4, rd4, rs1_4, rs2_4);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] asynchronous reset mid-shift checked");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sw();
    test_lui_beq();
    test_jal_widths();
    test_csr_imm();
    test_idle_err();
    test_done_early();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qerv_immdec_w.md
Name: qerv_immdec_w

Overview:
- Parametrised W-bit-per-cycle immediate decoder for the bit/nibble-serial core family; replaces the fixed 4-lane decoder.
- Captures instruction bits from the instruction bus and latches the register addresses.
- Assembles the immediate for the current format and shifts it out LSB-first, W bits per count beat, with sign extension.
- Adds a working serial CSR immediate, a beat counter and a sequence-error flag. Sits between the instruction bus and the serial ALU/CSR datapath.

Parameters:
- W, 4: bits per beat; legal values 1, 2, 4, 8. N = 32/W beats per immediate. Any other value is an elaboration error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_wb_en  in  1  instruction bus ack; capture i_wb_rdt
- i_wb_rdt  in  25  instruction bits [31:7]
- i_imm_type  in  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5..7 decode as I
- i_cnt_en  in  1  beat strobe; shift by W
- i_cnt_done  in  1  core's last-beat indication (checked only)
- i_csr_imm_en  in  1  gate for o_csr_imm
- o_rd_addr  out  5  instr[11:7]
- o_rs1_addr  out  5  instr[19:15]
- o_rs2_addr  out  5  instr[24:20]
- o_imm  out  W  current immediate slice
- o_csr_imm  out  W  current zero-extended rs1-field slice, 0 when i_csr_imm_en=0
- o_last  out  1  beat counter == N-1 and state SHIFT
- o_err  out  1  sticky sequence error

Behaviour:
- Reset (async assert): state IDLE; raw, shift and CSR registers 0; counter 0; addresses 0; o_imm=0, o_csr_imm=0, o_last=0, o_err=0. Deassertion is synchronous to the next i_clk edge.
- States: IDLE, CAPT, SHIFT.
- Capture: i_wb_en in any state latches raw[31:7] and the three addresses, clears the counter, and enters CAPT next cycle. i_wb_en has priority over i_cnt_en, which means a mid-sequence restart discards the old immediate.
- CAPT (exactly 1 cycle):
  - i_imm_type is sampled.
  - The shift register loads the assembled 32-bit immediate:
    - I: sext(raw[31:20])
    - S: sext({raw[31:25], raw[11:7]})
    - B: sext({raw[31], raw[7], raw[30:25], raw[11:8], 1'b0})
    - U: {raw[31:12], 12'b0}
    - J: sext({raw[31], raw[19:12], raw[20], raw[30:21], 1'b0})
  - The CSR register loads {27'b0, raw[19:15]}.
  - Next state is SHIFT.
  - i_cnt_en in CAPT is ignored and sets o_err.
- SHIFT:
  - o_imm = shreg[W-1:0] combinationally.
  - On i_cnt_en, shreg shifts right by W, and the top W bits fill with the sign (shreg[31]).
  - The CSR register shifts right by W, zero-filled.
  - The counter increments.
  - On i_cnt_en with counter == N-1, the next state is IDLE and the counter returns to 0.
  - Without i_cnt_en, all values hold (stall is legal for any number of cycles).
- IDLE: o_imm=0, o_csr_imm=0. i_cnt_en is ignored and sets o_err.
- Check: i_cnt_done=1 with o_last=0, or i_cnt_en with o_last=1 and i_cnt_done=0, sets o_err. o_err clears only on i_rst.
- Addresses hold from capture until the next i_wb_en; they do not shift.
- Latency: first slice valid 2 cycles after the i_wb_en edge; a full immediate takes N i_cnt_en beats.
- Width rules:
  - The counter is clog2(N) bits, minimum 1 bit.
  - W=8 gives N=4.
  - W=1 gives N=32, the pure bit-serial case.

Optional Feature:
- Macro QERV_IMMDEC_CSR_EN.
- Defined: the CSR shift register exists and o_csr_imm behaves as above.
- Undefined: the CSR register is not built and o_csr_imm is tied to 0. All other behaviour is identical.

Test Plan:
- W=4, addi x1,x2,-1 (0xFFF10093), type I, 8 beats -> o_imm=F on every beat; o_rd_addr=1, o_rs1_addr=2; o_last on beat 7; o_err=0.
- W=4, sw x5,8(x2) (0x00512423), type S -> beats 8,0,0,0,0,0,0,0; o_rs2_addr=5.
- W=4, lui x1,0x12345 (0x123450B7), type U -> beats 0,0,0,5,4,3,2,1. Then beq x0,x0,16 (0x00000863), type B -> 0,1,0,0,0,0,0,0.
- W=1 and W=8, jal x0,-4 (0xFFDFF06F), type J:
  - W=8 -> FC,FF,FF,FF.
  - W=1 -> bits 0,0,1 then 29 ones.
  - Insert 3-cycle i_cnt_en stalls mid-sequence -> identical output.
- W=4 with QERV_IMMDEC_CSR_EN, csrrwi x0,0x300,21 (0x300AD073), i_csr_imm_en=1 -> o_csr_imm 5,1,0,0,0,0,0,0. The same run without the macro -> o_csr_imm=0 throughout.
- Error/reset cases:
  - i_cnt_en in IDLE -> o_err=1, sticky.
  - i_cnt_done on beat 3 of 8 -> o_err=1.
  - i_wb_en on beat 4 -> restart, new immediate from beat 0.
  - i_rst mid-SHIFT -> all outputs 0 immediately, without waiting for a clock edge.
